// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the E0C6S46 register write-back path.
// Holds the destination and post-increment selectors, the FSM state type,
// and the flag bit positions, page constants and PC field codes.
package reg_writeback_pkg;

  typedef enum logic [4:0] {
    REG_A, REG_B, REG_TEMPA, REG_TEMPB,
    REG_XL, REG_XH, REG_XP, REG_YL, REG_YH, REG_YP,
    REG_SPL, REG_SPH, REG_FLAGS,
    REG_PCSL, REG_PCSH, REG_PCP,
    REG_MX, REG_MY, REG_MSP, REG_MN,
    REG_IMM_ADDR_L, REG_IMM_ADDR_H, REG_IMM_ADDR_P,
    REG_ALU, REG_ALU_WITH_FLAGS, REG_IMML, REG_IMMH, REG_HARDCODED_1
  } reg_type;

  typedef enum logic [1:0] {REG_NONE, REG_XHL, REG_YHL, REG_SP} reg_inc_type;

  typedef enum logic [1:0] {WB_IDLE, WB_MEM, WB_INC} wb_state;

  localparam int FLAG_I = 3;
  localparam int FLAG_D = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  localparam logic [3:0] MSP_PAGE = 4'h0;
  localparam logic [7:0] MN_PAGE  = 8'h00;

  localparam logic [1:0] PC_FIELD_SL = 2'd0;
  localparam logic [1:0] PC_FIELD_SH = 2'd1;
  localparam logic [1:0] PC_FIELD_P  = 2'd2;

  // Two-bit register-pair code used by the IMM_ADDR destinations.
  function automatic reg_type imm_sel(input logic [1:0] s);
    case (s)
      2'b00:   return REG_A;
      2'b01:   return REG_B;
      2'b10:   return REG_MX;
      default: return REG_MY;
    endcase
  endfunction

endpackage

// File: rtl/writeback_addr_gen.sv
// Resolves IMM_ADDR destinations to a concrete target and forms the memory address.
// Purely combinational, zero latency.
// No handshake; the parent samples the results on the accepting edge.
module writeback_addr_gen
  import reg_writeback_pkg::*;
(
  input  reg_type     dest,
  input  logic [5:0]  imm,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [7:0]  sp,
  output reg_type     dest_res,
  output logic [11:0] addr
);

  // Map the immediate-addressed forms onto A/B/MX/MY, then pick the address source.
  always_comb begin
    dest_res = dest;
    case (dest)
      REG_IMM_ADDR_L: dest_res = imm_sel(imm[1:0]);
      REG_IMM_ADDR_H: dest_res = imm_sel(imm[3:2]);
      REG_IMM_ADDR_P: dest_res = imm_sel(imm[5:4]);
      default:        dest_res = dest;
    endcase

    addr = 12'h000;
    case (dest_res)
      REG_MX:  addr = x;
      REG_MY:  addr = y;
      REG_MSP: addr = {MSP_PAGE, sp};
      REG_MN:  addr = {MN_PAGE, imm[3:0]};
      default: addr = 12'h000;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-back unit: commits a nibble to a core register, the PC unit or data memory, then post-increments.
// Register/PC writes take effect on the accepting edge; memory writes wait for mem_ack; increment costs one extra cycle.
// wr_ready is high only in IDLE; with WRITEBACK_TIMEOUT_EN defined a missing mem_ack aborts after MEM_TIMEOUT cycles.
module reg_writeback
  import reg_writeback_pkg::*;
`ifdef WRITEBACK_TIMEOUT_EN
  #(parameter int MEM_TIMEOUT = 15)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  reg_type     wr_dest,
  input  logic [3:0]  wr_data,
  input  reg_inc_type wr_inc,
  input  logic        wr_sp_dec,
  input  logic [5:0]  wr_imm,
  output logic [3:0]  a,
  output logic [3:0]  b,
  output logic [3:0]  temp_a,
  output logic [3:0]  temp_b,
  output logic [3:0]  flags,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [7:0]  sp,
  output logic        pc_wr,
  output logic [1:0]  pc_wr_field,
  output logic [3:0]  pc_wr_data,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  output logic [3:0]  mem_wdata,
  input  logic        mem_ack,
  output logic        wr_err
);

  wb_state     state;
  reg_inc_type inc_q;
  logic        sp_dec_q;
  reg_type     dest_res;
  logic [11:0] addr_res;
  logic        accept;
  logic        has_inc;

`ifdef WRITEBACK_TIMEOUT_EN
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  assign accept  = wr_valid && wr_ready;
  assign has_inc = (wr_inc != REG_NONE);

  writeback_addr_gen u_addr_gen (
    .dest     (wr_dest),
    .imm      (wr_imm),
    .x        (x),
    .y        (y),
    .sp       (sp),
    .dest_res (dest_res),
    .addr     (addr_res)
  );

  // Write-back FSM: register/PC commits in IDLE, memory handshake in MEM, post-increment in INC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WB_IDLE;
      wr_ready    <= 1'b0;
      inc_q       <= REG_NONE;
      sp_dec_q    <= 1'b0;
      a           <= 4'h0;
      b           <= 4'h0;
      temp_a      <= 4'h0;
      temp_b      <= 4'h0;
      flags       <= 4'h0;
      x           <= 12'h000;
      y           <= 12'h000;
      sp          <= 8'h00;
      pc_wr       <= 1'b0;
      pc_wr_field <= 2'd0;
      pc_wr_data  <= 4'h0;
      mem_req     <= 1'b0;
      mem_addr    <= 12'h000;
      mem_wdata   <= 4'h0;
      wr_err      <= 1'b0;
`ifdef WRITEBACK_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      pc_wr  <= 1'b0;
      wr_err <= 1'b0;
      case (state)
        WB_IDLE: begin
          wr_ready <= 1'b1;
`ifdef WRITEBACK_TIMEOUT_EN
          to_cnt   <= '0;
`endif
          if (accept) begin
            inc_q    <= wr_inc;
            sp_dec_q <= wr_sp_dec;
            state    <= has_inc ? WB_INC : WB_IDLE;
            wr_ready <= !has_inc;
            case (dest_res)
              REG_A:     a         <= wr_data;
              REG_B:     b         <= wr_data;
              REG_TEMPA: temp_a    <= wr_data;
              REG_TEMPB: temp_b    <= wr_data;
              REG_XL:    x[3:0]    <= wr_data;
              REG_XH:    x[7:4]    <= wr_data;
              REG_XP:    x[11:8]   <= wr_data;
              REG_YL:    y[3:0]    <= wr_data;
              REG_YH:    y[7:4]    <= wr_data;
              REG_YP:    y[11:8]   <= wr_data;
              REG_SPL:   sp[3:0]   <= wr_data;
              REG_SPH:   sp[7:4]   <= wr_data;
              REG_FLAGS: flags     <= wr_data;
              REG_PCSL, REG_PCSH, REG_PCP: begin
                pc_wr       <= 1'b1;
                pc_wr_field <= (dest_res == REG_PCSL) ? PC_FIELD_SL :
                               (dest_res == REG_PCSH) ? PC_FIELD_SH : PC_FIELD_P;
                pc_wr_data  <= wr_data;
              end
              REG_MX, REG_MY, REG_MSP, REG_MN: begin
                mem_req   <= 1'b1;
                mem_addr  <= addr_res;
                mem_wdata <= wr_data;
                state     <= WB_MEM;
                wr_ready  <= 1'b0;
              end
              // Illegal targets write nothing but still flag and still increment.
              default:   wr_err    <= 1'b1;
            endcase
          end
        end
        WB_MEM: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= (inc_q != REG_NONE) ? WB_INC : WB_IDLE;
            wr_ready <= (inc_q == REG_NONE);
          end
`ifdef WRITEBACK_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            mem_req  <= 1'b0;
            wr_err   <= 1'b1;
            state    <= WB_IDLE;
            wr_ready <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WB_INC: begin
          case (inc_q)
            REG_XHL: x[7:0] <= x[7:0] + 8'd1;
            REG_YHL: y[7:0] <= y[7:0] + 8'd1;
            REG_SP:  sp     <= sp_dec_q ? sp - 8'd1 : sp + 8'd1;
            default: ;
          endcase
          state    <= WB_IDLE;
          wr_ready <= 1'b1;
        end
        default: begin
          state    <= WB_IDLE;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback.
// Drives and samples 1 ns after each rising clock edge.
// Covers register, PC, memory, increment, illegal-destination and reset paths.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  reg_type     wr_dest;
  logic [3:0]  wr_data;
  reg_inc_type wr_inc;
  logic        wr_sp_dec;
  logic [5:0]  wr_imm;
  logic [3:0]  a, b, temp_a, temp_b, flags;
  logic [11:0] x, y;
  logic [7:0]  sp;
  logic        pc_wr;
  logic [1:0]  pc_wr_field;
  logic [3:0]  pc_wr_data;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [3:0]  mem_wdata;
  logic        mem_ack;
  logic        wr_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_dest(wr_dest), .wr_data(wr_data), .wr_inc(wr_inc), .wr_sp_dec(wr_sp_dec),
    .wr_imm(wr_imm), .a(a), .b(b), .temp_a(temp_a), .temp_b(temp_b), .flags(flags),
    .x(x), .y(y), .sp(sp), .pc_wr(pc_wr), .pc_wr_field(pc_wr_field),
    .pc_wr_data(pc_wr_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .wr_err(wr_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns 1 ns after the accepting edge.
  task automatic do_write(input reg_type d, input logic [3:0] dat, input reg_inc_type inc,
                          input logic [5:0] imm, input logic dec);
    wr_dest   = d;
    wr_data   = dat;
    wr_inc    = inc;
    wr_imm    = imm;
    wr_sp_dec = dec;
    wr_valid  = 1'b1;
    cyc();
    wr_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_valid = 1'b0; wr_dest = REG_A; wr_data = 4'h0;
    wr_inc = REG_NONE; wr_sp_dec = 1'b0; wr_imm = 6'h00; mem_ack = 1'b0;
    #2;
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if ({a, b, temp_a, temp_b, flags} !== 20'h0) begin fails++; $display("FAIL reset_regs: got %h want 0", {a, b, temp_a, temp_b, flags}); end
    checks++; if ({x, y, sp} !== 32'h0) begin fails++; $display("FAIL reset_xysp: got %h want 0", {x, y, sp}); end
    checks++; if ({pc_wr, pc_wr_field, pc_wr_data, wr_err, mem_addr, mem_wdata} !== 24'h0) begin fails++; $display("FAIL reset_outs: got %h want 0", {pc_wr, pc_wr_field, pc_wr_data, wr_err, mem_addr, mem_wdata}); end
    cyc(); cyc();
    reset_n = 1'b1;
    checks++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_lo: got %b want 0", wr_ready); end
    cyc();
    checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_hi: got %b want 1", wr_ready); end
  endtask

  task automatic test_back_to_back();
    do_write(REG_A, 4'h5, REG_NONE, 6'h00, 1'b0);
    checks++; if (a !== 4'h5 || wr_ready !== 1'b1) begin fails++; $display("FAIL b2b_a: got a=%h rdy=%b want a=5 rdy=1", a, wr_ready); end
    do_write(REG_B, 4'hA, REG_NONE, 6'h00, 1'b0);
    checks++; if (a !== 4'h5 || b !== 4'hA || wr_ready !== 1'b1) begin fails++; $display("FAIL b2b_b: got a=%h b=%h rdy=%b want 5 A 1", a, b, wr_ready); end
    do_write(REG_TEMPA, 4'h1, REG_NONE, 6'h00, 1'b0);
    do_write(REG_TEMPB, 4'h2, REG_NONE, 6'h00, 1'b0);
    do_write(REG_FLAGS, 4'b0110, REG_NONE, 6'h00, 1'b0);
    checks++; if (temp_a !== 4'h1 || temp_b !== 4'h2) begin fails++; $display("FAIL b2b_temp: got %h %h want 1 2", temp_a, temp_b); end
    checks++; if (flags[FLAG_I] !== 1'b0 || flags[FLAG_D] !== 1'b1 || flags[FLAG_Z] !== 1'b1 || flags[FLAG_C] !== 1'b0) begin fails++; $display("FAIL b2b_flags: got %b want 0110", flags); end
  endtask

  task automatic test_mem_x_inc();
    do_write(REG_XL, 4'hF, REG_NONE, 6'h00, 1'b0);
    do_write(REG_XH, 4'hF, REG_NONE, 6'h00, 1'b0);
    do_write(REG_XP, 4'h3, REG_NONE, 6'h00, 1'b0);
    checks++; if (x !== 12'h3FF) begin fails++; $display("FAIL x_setup: got %h want 3FF", x); end
    do_write(REG_MX, 4'h7, REG_XHL, 6'h00, 1'b0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h3FF || mem_wdata !== 4'h7 || wr_ready !== 1'b0) begin fails++; $display("FAIL mx_start: got req=%b addr=%h data=%h rdy=%b want 1 3FF 7 0", mem_req, mem_addr, mem_wdata, wr_ready); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h3FF || mem_wdata !== 4'h7) begin fails++; $display("FAIL mx_hold%0d: got req=%b addr=%h data=%h want 1 3FF 7", i, mem_req, mem_addr, mem_wdata); end
    end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || x !== 12'h3FF) begin fails++; $display("FAIL mx_ack: got req=%b x=%h want 0 3FF", mem_req, x); end
    cyc();
    checks++; if (x !== 12'h300 || wr_ready !== 1'b1) begin fails++; $display("FAIL mx_inc: got x=%h rdy=%b want 300 1", x, wr_ready); end
  endtask

  task automatic test_msp_dec();
    do_write(REG_MSP, 4'h3, REG_SP, 6'h00, 1'b1);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h000 || mem_wdata !== 4'h3) begin fails++; $display("FAIL msp_start: got req=%b addr=%h data=%h want 1 000 3", mem_req, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || sp !== 8'h00) begin fails++; $display("FAIL msp_ack: got req=%b sp=%h want 0 00", mem_req, sp); end
    cyc();
    checks++; if (sp !== 8'hFF || wr_ready !== 1'b1) begin fails++; $display("FAIL msp_dec: got sp=%h rdy=%b want FF 1", sp, wr_ready); end
  endtask

  task automatic test_imm_addr();
    do_write(REG_YL, 4'h3, REG_NONE, 6'h00, 1'b0);
    do_write(REG_YH, 4'h2, REG_NONE, 6'h00, 1'b0);
    do_write(REG_YP, 4'h1, REG_NONE, 6'h00, 1'b0);
    checks++; if (y !== 12'h123) begin fails++; $display("FAIL y_setup: got %h want 123", y); end
    do_write(REG_IMM_ADDR_H, 4'h9, REG_NONE, 6'b00_11_00, 1'b0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h123 || mem_wdata !== 4'h9) begin fails++; $display("FAIL immh_my: got req=%b addr=%h data=%h want 1 123 9", mem_req, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || wr_ready !== 1'b1) begin fails++; $display("FAIL immh_done: got req=%b rdy=%b want 0 1", mem_req, wr_ready); end
    do_write(REG_IMM_ADDR_L, 4'h3, REG_NONE, 6'b11_10_01, 1'b0);
    checks++; if (b !== 4'h3 || mem_req !== 1'b0) begin fails++; $display("FAIL imml_b: got b=%h req=%b want 3 0", b, mem_req); end
    do_write(REG_MN, 4'h2, REG_NONE, 6'h35, 1'b0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h005 || mem_wdata !== 4'h2) begin fails++; $display("FAIL mn_addr: got req=%b addr=%h data=%h want 1 005 2", mem_req, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic test_pc_write();
    do_write(REG_PCSH, 4'hC, REG_NONE, 6'h00, 1'b0);
    checks++; if (pc_wr !== 1'b1 || pc_wr_field !== 2'd1 || pc_wr_data !== 4'hC) begin fails++; $display("FAIL pcsh: got wr=%b field=%0d data=%h want 1 1 C", pc_wr, pc_wr_field, pc_wr_data); end
    cyc();
    checks++; if (pc_wr !== 1'b0) begin fails++; $display("FAIL pcsh_pulse: got %b want 0", pc_wr); end
  endtask

  task automatic test_illegal();
    do_write(REG_IMML, 4'hF, REG_NONE, 6'h00, 1'b0);
    checks++; if (wr_err !== 1'b1 || a !== 4'h5 || b !== 4'h3 || wr_ready !== 1'b1) begin fails++; $display("FAIL imml_err: got err=%b a=%h b=%h rdy=%b want 1 5 3 1", wr_err, a, b, wr_ready); end
    cyc();
    checks++; if (wr_err !== 1'b0) begin fails++; $display("FAIL imml_pulse: got %b want 0", wr_err); end
    do_write(REG_ALU, 4'h6, REG_YHL, 6'h00, 1'b0);
    checks++; if (wr_err !== 1'b1 || y !== 12'h123) begin fails++; $display("FAIL alu_err: got err=%b y=%h want 1 123", wr_err, y); end
    cyc();
    checks++; if (wr_err !== 1'b0 || y !== 12'h124 || wr_ready !== 1'b1) begin fails++; $display("FAIL alu_inc: got err=%b y=%h rdy=%b want 0 124 1", wr_err, y, wr_ready); end
  endtask

  task automatic test_xl_carry();
    do_write(REG_XL, 4'hF, REG_XHL, 6'h00, 1'b0);
    checks++; if (x !== 12'h30F || wr_ready !== 1'b0) begin fails++; $display("FAIL xl_write: got x=%h rdy=%b want 30F 0", x, wr_ready); end
    cyc();
    checks++; if (x !== 12'h310) begin fails++; $display("FAIL xl_carry: got %h want 310", x); end
  endtask

  task automatic test_mem_wait();
    int held;
    do_write(REG_MY, 4'h1, REG_NONE, 6'h00, 1'b0);
`ifdef WRITEBACK_TIMEOUT_EN
    held = 0;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      held++;
      cyc();
    end
    checks++; if (held !== 15) begin fails++; $display("FAIL timeout_len: got %0d want 15", held); end
    checks++; if (mem_req !== 1'b0 || wr_err !== 1'b1 || wr_ready !== 1'b1) begin fails++; $display("FAIL timeout_end: got req=%b err=%b rdy=%b want 0 1 1", mem_req, wr_err, wr_ready); end
`else
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1 && mem_addr === 12'h124) held++;
      cyc();
    end
    checks++; if (held !== 20) begin fails++; $display("FAIL mem_wait: got %0d held cycles want 20", held); end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || wr_ready !== 1'b1) begin fails++; $display("FAIL mem_wait_ack: got req=%b rdy=%b want 0 1", mem_req, wr_ready); end
`endif
  endtask

  task automatic test_reset_mid_mem();
    do_write(REG_MX, 4'h4, REG_XHL, 6'h00, 1'b0);
    checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_mem_pre: got %b want 1", mem_req); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || wr_ready !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got req=%b rdy=%b want 0 0", mem_req, wr_ready); end
    checks++; if ({a, b, x, y, sp} !== 40'h0 || mem_addr !== 12'h000) begin fails++; $display("FAIL rst_mem_regs: got %h addr=%h want 0", {a, b, x, y, sp}, mem_addr); end
    cyc(); cyc();
    reset_n = 1'b1;
    cyc(); cyc();
    checks++; if (mem_req !== 1'b0 || wr_ready !== 1'b1 || x !== 12'h000) begin fails++; $display("FAIL rst_mem_after: got req=%b rdy=%b x=%h want 0 1 000", mem_req, wr_ready, x); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mem_x_inc();
    test_msp_dec();
    test_imm_addr();
    test_pc_write();
    test_illegal();
    test_xl_carry();
    test_mem_wait();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
